// File: rtl/md_unit.sv
// Multiply/divide sequencer: owns HI/LO and models multi-cycle mult/div latency via busy/stall_req.
// Optional madd/msub accumulate support is enabled by defining MD_MADD_EN.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [4:0] MULT_CNT = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_CNT  = 5'(DIV_CYCLES);

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] hi_nxt, lo_nxt;

  logic is_mul, is_div, is_acc, long_op;

  always_comb begin
    is_mul = (md_op == 3'd0) || (md_op == 3'd1);
    is_div = (md_op == 3'd2) || (md_op == 3'd3);
`ifdef MD_MADD_EN
    is_acc = (md_op == 3'd6) || (md_op == 3'd7);
`else
    is_acc = 1'b0;
`endif
    long_op = is_mul || is_div || is_acc;
  end

  assign stall_req = busy | (start & long_op);

  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide is done on magnitudes so the most-negative / -1 case stays well defined.
  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b, den, q_mag, r_mag, quot, rem;

  always_comb begin
    a_neg = (md_op == 3'd2) && a[31];
    b_neg = (md_op == 3'd2) && b[31];
    mag_a = a_neg ? (32'd0 - a) : a;
    mag_b = b_neg ? (32'd0 - b) : b;
    den   = (b == 32'd0) ? 32'd1 : mag_b;
    q_mag = mag_a / den;
    r_mag = mag_a % den;
    quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem   = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  logic [63:0] acc_sum;
`ifdef MD_MADD_EN
  assign acc_sum = (md_op == 3'd6) ? ({hi, lo} + prod_s) : ({hi, lo} - prod_s);
`else
  assign acc_sum = {hi, lo};
`endif

  logic [31:0] res_hi, res_lo;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    case (md_op)
      3'd0: {res_hi, res_lo} = prod_s;
      3'd1: {res_hi, res_lo} = prod_u;
      3'd2, 3'd3: begin
        if (b != 32'd0) begin
          res_hi = rem;
          res_lo = quot;
        end
      end
      3'd6, 3'd7: {res_hi, res_lo} = acc_sum;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      busy   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      hi_nxt <= 32'd0;
      lo_nxt <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (long_op) begin
              hi_nxt <= res_hi;
              lo_nxt <= res_lo;
              cnt    <= is_div ? DIV_CNT : MULT_CNT;
              busy   <= 1'b1;
              state  <= RUN;
            end else if (md_op == 3'd4) begin
              hi <= a;
            end else if (md_op == 3'd5) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          if (cnt == 5'd1) begin
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            cnt   <= 5'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (default parameters; honours MD_MADD_EN if defined).
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy, stall_req;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_err = 0;
  int bcnt;

  md_unit dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .a(a), .b(b), .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op on the next edge, then count busy cycles (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                        input logic exp_stall);
    @(negedge clk);
    start = 1'b1; md_op = op; a = va; b = vb;
    #1 chk("stall_req", {63'd0, stall_req}, {63'd0, exp_stall});
    @(posedge clk);
    #1 start = 1'b0;
    bcnt = 0;
    while (busy && bcnt < 40) begin
      @(posedge clk);
      #1 bcnt++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk) reset = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFFFFFD, 1'b1);
    chk("mult_cycles", 64'(bcnt), 64'd5);
    chk("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

    run_op(3'd3, 32'd100, 32'd7, 1'b1);
    chk("divu_cycles", 64'(bcnt), 64'd10);
    chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});

    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b1);
    chk("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    run_op(3'd1, 32'hFFFFFFFF, 32'd2, 1'b1);
    chk("multu_hilo", {hi, lo}, 64'h00000001_FFFFFFFE);

    run_op(3'd4, 32'h12345678, 32'd0, 1'b0);
    chk("mthi_busy", 64'(bcnt), 64'd0);
    chk("mthi_hi", {32'd0, hi}, {32'd0, 32'h12345678});

    // mtlo presented during RUN must be ignored.
    run_op(3'd0, 32'd3, 32'd4, 1'b1);
    chk("mult34_hilo", {hi, lo}, {32'd0, 32'd12});
    @(negedge clk);
    start = 1'b1; md_op = 3'd1; a = 32'd2; b = 32'd2;
    @(posedge clk);
    #1 md_op = 3'd5; a = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1 chk("run_stall", {63'd0, stall_req}, 64'd1);
    start = 1'b0;
    bcnt = 0;
    while (busy && bcnt < 40) begin
      @(posedge clk);
      #1 bcnt++;
    end
    chk("mtlo_in_run", {hi, lo}, {32'd0, 32'd4});

    run_op(3'd0, 32'd3, 32'd4, 1'b1);
    run_op(3'd2, 32'd55, 32'd0, 1'b1);
    chk("div0_cycles", 64'(bcnt), 64'd10);
    chk("div0_hilo", {hi, lo}, {32'd0, 32'd12});

    // Reset on cycle 3 of RUN aborts without commit.
    @(negedge clk);
    start = 1'b1; md_op = 3'd0; a = 32'd5; b = 32'd6;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk) reset = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("abort_nocommit", {hi, lo}, 64'd0);

    run_op(3'd4, 32'd0, 32'd0, 1'b0);
    run_op(3'd5, 32'd5, 32'd0, 1'b0);
    chk("mtlo_lo", {32'd0, lo}, {32'd0, 32'd5});
`ifdef MD_MADD_EN
    run_op(3'd6, 32'd2, 32'd3, 1'b1);
    chk("madd_cycles", 64'(bcnt), 64'd5);
    chk("madd_hilo", {hi, lo}, {32'd0, 32'd11});
    run_op(3'd7, 32'd1, 32'd12, 1'b1);
    chk("msub_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
`else
    run_op(3'd6, 32'd2, 32'd3, 1'b0);
    chk("madd_off_busy", 64'(bcnt), 64'd0);
    chk("madd_off_hilo", {hi, lo}, {32'd0, 32'd5});
    run_op(3'd7, 32'd1, 32'd12, 1'b0);
    chk("msub_off_hilo", {hi, lo}, {32'd0, 32'd5});
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide sequencer for the pipelined MIPS32 core. Sits beside the ALU in the EX stage, owns the architectural HI/LO registers, and models multi-cycle mult/div latency with a countdown that raises `busy`. The hazard unit uses `stall_req` to freeze IF/ID/EX while a multiply-class instruction is pending. The main controller supplies `start` and `md_op`, decoded from the instruction word.

## Interface
- `MULT_CYCLES`, 5, busy cycles for mult/multu (and madd/msub); legal range 1..31
- `DIV_CYCLES`, 10, busy cycles for div/divu; legal range 1..31

- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; clears all state
- `start`  in  1  EX-stage instruction is a md_unit op; qualifies `md_op`
- `md_op`  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 msub
- `a`  in  32  rs operand (forwarded value)
- `b`  in  32  rt operand (forwarded value)
- `busy`  out  1  operation in progress
- `stall_req`  out  1  combinational: `busy | (start & md_op<=3 or 6/7)`
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- Two-state FSM: IDLE, RUN. Count register `cnt` is 5 bits.
- IDLE, `start`=1, `md_op` in {0,1,2,3,6,7}: latch result into `hi_nxt`/`lo_nxt`, load `cnt` = MULT_CYCLES or DIV_CYCLES, go to RUN.
- Results: mult/multu: 64-bit product, `{hi,lo}`. div/divu: `lo` = quotient, `hi` = remainder, truncating toward zero; remainder takes dividend's sign. madd/msub: `{hi,lo}` ± signed 64-bit product, wrap modulo 2^64.
- Division by zero (`b`=0): still goes busy for DIV_CYCLES; HI/LO keep their prior values on completion.
- IDLE, `start`=1, `md_op`=4/5: `hi`/`lo` ← `a` on that edge; no busy, FSM remains in IDLE.
- RUN: `cnt` decrements each cycle; when `cnt`=1, commit `hi_nxt`/`lo_nxt` to `hi`/`lo` and return to IDLE.
- `start` while in RUN is ignored (including mthi/mtlo). The hazard unit guarantees the stalled instruction is re-presented after `busy` falls.
- `reset` overrides everything: FSM→IDLE, `cnt`=0, `busy`=0, `hi`=`lo`=0, staged results=0.

## Timing
- Reset values: `busy`=0, `hi`=0, `lo`=0. `stall_req` follows its inputs combinationally.
- `start` sampled at edge t → `busy`=1 after edge t, stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES). `busy` falls and `hi`/`lo` update on edge t+N.
- A new op may start on edge t+N+... i.e. first edge at which `busy`=0 is sampled; back-to-back is legal (start at edge t+N+1 sampled with busy=0).
- mthi/mtlo: 1-cycle latency; the new value is visible after the sampling edge.
- Reset asserted mid-RUN: aborts on that edge, with no commit.

## Configuration
- `MD_MADD_EN` defined: `md_op` 6/7 (madd/msub) are supported as above.
- Undefined: `md_op` 6/7 are treated as no-ops (no busy, no HI/LO change, and do not drive `stall_req` beyond `busy`). The accumulate adder is removed.

## Test plan
- Reset, then `mult` a=7, b=0xFFFFFFFD → `busy` high 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- `divu` a=100, b=7 → `busy` high 10 cycles; `lo`=14, `hi`=2. `div` a=0xFFFFFFF9, b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- `mthi` a=0x12345678 while idle → `hi`=0x12345678 next cycle, `busy` never rises. A `mtlo` issued during RUN leaves `lo` unchanged.
- `div` with b=0 after `mult` 3×4 → `busy` 10 cycles; `hi`=0, `lo`=12 retained.
- Start `mult`, assert `reset` on cycle 3 of RUN → `busy`=0, `hi`=`lo`=0 next cycle; no later commit.
- With `MD_MADD_EN`: hi/lo=0:5, `madd` a=2, b=3 → after 5 cycles `lo`=11. `msub` a=1, b=12 → `{hi,lo}`=0xFFFFFFFF_FFFFFFFF. Without the macro: op 6 leaves `lo`=5 and `busy`=0.
